// File: rtl/dma_req_responder_if.sv
// DMA request handshake, Avalon-MM data-register port and streaming port of
// the DMA request responder, bundled as one interface.
// master: the responder side. slave: the peripheral / stream environment.
interface dma_req_responder_if #(
  parameter int DATA_W = 32
);
  logic              dma_req;
  logic              dma_single;
  logic              dma_ack;
  logic              avm_read;
  logic              avm_write;
  logic [DATA_W-1:0] avm_writedata;
  logic [DATA_W-1:0] avm_readdata;
  logic              avm_waitrequest;
  logic [DATA_W-1:0] st_data_o;
  logic              st_valid_o;
  logic              st_ready_i;
  logic [DATA_W-1:0] st_data_i;
  logic              st_valid_i;
  logic              st_ready_o;

  modport master (
    input  dma_req, dma_single, avm_readdata, avm_waitrequest,
           st_ready_i, st_data_i, st_valid_i,
    output dma_ack, avm_read, avm_write, avm_writedata,
           st_data_o, st_valid_o, st_ready_o
  );

  modport slave (
    output dma_req, dma_single, avm_readdata, avm_waitrequest,
           st_ready_i, st_data_i, st_valid_i,
    input  dma_ack, avm_read, avm_write, avm_writedata,
           st_data_o, st_valid_o, st_ready_o
  );
endinterface

// File: rtl/dma_req_responder.sv
// DMA request responder: services burst/single DMA requests by moving beats
// between a peripheral data register (Avalon-MM) and a stream.
// DIR=0 reads the register into the stream, DIR=1 writes stream data to it.
// Optional feature macro: DMA_RESP_TIMEOUT_EN (release timeout in REL, sets err).
module dma_req_responder #(
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 8,
  parameter int CNT_W     = 16,
  parameter int DIR       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [CNT_W-1:0] xfer_len,
  input  logic             enable,
  output logic             busy,
  output logic             done,
  output logic             err,
  dma_req_responder_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_BEAT, S_ACK, S_REL} state_t;

  // Beat sub-phases. DIR=0: P_A = read, P_B = stream out.
  // DIR=1: P_A = wait for stream valid, P_B = one-cycle ready, P_C = write.
  localparam logic [1:0] P_A = 2'd0;
  localparam logic [1:0] P_B = 2'd1;
  localparam logic [1:0] P_C = 2'd2;

  state_t            r_state, w_state_next;
  logic [1:0]        r_phase, w_phase_next;
  logic [CNT_W-1:0]  r_remaining, w_remaining_next;
  logic [7:0]        r_beats, w_beats_next;
  logic [DATA_W-1:0] r_data, w_data_next;
  logic              r_busy, w_busy_next;
  logic              r_done, w_done_next;
  logic              w_beat_done;
`ifdef DMA_RESP_TIMEOUT_EN
  logic              r_err, w_err_next;
  logic [7:0]        r_tmo, w_tmo_next;
`endif

  // Next-state and datapath decisions; requests are looked at in the very
  // cycle ARM is entered, so a pending request costs no extra cycle.
  always_comb begin
    w_state_next     = r_state;
    w_phase_next     = r_phase;
    w_remaining_next = r_remaining;
    w_beats_next     = r_beats;
    w_data_next      = r_data;
    w_busy_next      = r_busy;
    w_done_next      = 1'b0;
    w_beat_done      = 1'b0;
`ifdef DMA_RESP_TIMEOUT_EN
    w_err_next       = r_err;
    w_tmo_next       = 8'd0;
`endif
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_remaining_next = xfer_len;
          w_busy_next      = 1'b1;
          w_state_next     = S_ARM;
        end
      end
      S_ARM: begin
        w_phase_next = P_A;
        if (r_remaining == '0) begin
          // zero-length job: finish without touching the handshake
          w_state_next = S_IDLE;
          w_busy_next  = 1'b0;
          w_done_next  = 1'b1;
        end else if (enable) begin
          if (bus.dma_req && (r_remaining >= CNT_W'(BURST_LEN))) begin
            w_beats_next = 8'(BURST_LEN);
            w_state_next = S_BEAT;
          end else if (bus.dma_single) begin
            w_beats_next = 8'd1;
            w_state_next = S_BEAT;
          end
        end
      end
      S_BEAT: begin
        if (DIR == 0) begin
          if (r_phase == P_A) begin
            if (!bus.avm_waitrequest) begin
              w_data_next  = bus.avm_readdata;
              w_phase_next = P_B;
            end
          end else if (bus.st_ready_i) begin
            w_beat_done = 1'b1;
          end
        end else begin
          if (r_phase == P_A) begin
            if (bus.st_valid_i) w_phase_next = P_B;
          end else if (r_phase == P_B) begin
            w_data_next  = bus.st_data_i;
            w_phase_next = P_C;
          end else if (!bus.avm_waitrequest) begin
            w_beat_done = 1'b1;
          end
        end
        if (w_beat_done) begin
          w_remaining_next = r_remaining - CNT_W'(1);
          w_beats_next     = r_beats - 8'd1;
          w_phase_next     = P_A;
          if (r_beats == 8'd1) w_state_next = S_ACK;
        end
      end
      S_ACK: begin
        w_state_next = S_REL;
      end
      S_REL: begin
`ifdef DMA_RESP_TIMEOUT_EN
        w_tmo_next = r_tmo + 8'd1;
`endif
        if (!bus.dma_req && !bus.dma_single) begin
          if (r_remaining == '0) begin
            w_state_next = S_IDLE;
            w_busy_next  = 1'b0;
            w_done_next  = 1'b1;
          end else begin
            w_state_next = S_ARM;
          end
        end
`ifdef DMA_RESP_TIMEOUT_EN
        else if (r_tmo == 8'd255) begin
          // requester never released: give up on the job, no done pulse
          w_err_next   = 1'b1;
          w_state_next = S_IDLE;
          w_busy_next  = 1'b0;
        end
`endif
      end
      default: begin
        w_state_next = S_IDLE;
        w_busy_next  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset drops any beat in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_phase     <= P_A;
      r_remaining <= '0;
      r_beats     <= '0;
      r_data      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef DMA_RESP_TIMEOUT_EN
      r_err       <= 1'b0;
      r_tmo       <= 8'd0;
`endif
    end else begin
      r_state     <= w_state_next;
      r_phase     <= w_phase_next;
      r_remaining <= w_remaining_next;
      r_beats     <= w_beats_next;
      r_data      <= w_data_next;
      r_busy      <= w_busy_next;
      r_done      <= w_done_next;
`ifdef DMA_RESP_TIMEOUT_EN
      r_err       <= w_err_next;
      r_tmo       <= w_tmo_next;
`endif
    end
  end

  // Outputs decode registered state only; the unused direction stays at 0.
  assign busy              = r_busy;
  assign done              = r_done;
`ifdef DMA_RESP_TIMEOUT_EN
  assign err               = r_err;
`else
  assign err               = 1'b0;
`endif
  assign bus.dma_ack       = (r_state == S_ACK);
  assign bus.avm_read      = (DIR == 0) && (r_state == S_BEAT) && (r_phase == P_A);
  assign bus.st_valid_o    = (DIR == 0) && (r_state == S_BEAT) && (r_phase == P_B);
  assign bus.st_data_o     = (DIR == 0) ? r_data : '0;
  assign bus.st_ready_o    = (DIR != 0) && (r_state == S_BEAT) && (r_phase == P_B);
  assign bus.avm_write     = (DIR != 0) && (r_state == S_BEAT) && (r_phase == P_C);
  assign bus.avm_writedata = (DIR != 0) ? r_data : '0;

endmodule

// File: tb/tb_dma_req_responder.sv
// Bench for dma_req_responder: one DIR=0 and one DIR=1 instance, a vector
// table for the single-beat path plus hand-written multi-cycle sequences.
module tb_dma_req_responder;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic        start0, enable0, busy0, done0, err0;
  logic [15:0] xfer_len0;
  logic        start1, enable1, busy1, done1, err1;
  logic [15:0] xfer_len1;

  dma_req_responder_if #(.DATA_W(32)) if0 ();
  dma_req_responder_if #(.DATA_W(32)) if1 ();

  dma_req_responder #(.DATA_W(32), .BURST_LEN(8), .CNT_W(16), .DIR(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .start(start0), .xfer_len(xfer_len0),
    .enable(enable0), .busy(busy0), .done(done0), .err(err0), .bus(if0.master));

  dma_req_responder #(.DATA_W(32), .BURST_LEN(8), .CNT_W(16), .DIR(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .xfer_len(xfer_len1),
    .enable(enable1), .busy(busy1), .done(done1), .err(err1), .bus(if1.master));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end else begin
      $display("ok   %s value=%0h", name, act);
    end
  endtask

  typedef struct {
    bit st; logic [15:0] len; bit en; bit rq; bit sg; bit wt; bit rdy; logic [31:0] rd;
    bit b; bit d; bit a; bit r; bit v; logic [31:0] dat;
  } vec_t;

  function automatic vec_t mk(bit st, int len, bit en, bit rq, bit sg, bit wt, bit rdy,
                              logic [31:0] rd, bit b, bit d, bit a, bit r, bit v,
                              logic [31:0] dat);
    vec_t x;
    x.st = st; x.len = 16'(len); x.en = en; x.rq = rq; x.sg = sg; x.wt = wt;
    x.rdy = rdy; x.rd = rd; x.b = b; x.d = d; x.a = a; x.r = r; x.v = v; x.dat = dat;
    return x;
  endfunction

  // Full DIR=0 job: counts reads, checks stream order and ack spacing.
  task automatic run_dir0(input int len, input bit use_req, input bit use_single,
                          input int per_ack, input string tag);
    int rd_cnt = 0, st_cnt = 0, ack_cnt = 0, drop = 0, bad = 0, bad_ack = 0;
    bit fin = 0;
    start0 = 1'b1; xfer_len0 = 16'(len); enable0 = 1'b1;
    if0.dma_req = use_req; if0.dma_single = use_single;
    if0.avm_waitrequest = 1'b0; if0.st_ready_i = 1'b1; if0.avm_readdata = 32'h1000;
    for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
      @(posedge clk); #1;
      start0 = 1'b0;
      if0.avm_readdata = 32'h1000 + 32'(rd_cnt);
      if (if0.avm_read && !if0.avm_waitrequest) rd_cnt++;
      if (if0.st_valid_o && if0.st_ready_i) begin
        if (if0.st_data_o !== 32'h1000 + 32'(st_cnt)) bad++;
        st_cnt++;
      end
      if (if0.dma_ack) begin
        if (rd_cnt != (ack_cnt + 1) * per_ack) bad_ack++;
        ack_cnt++;
        drop = 2;
      end
      if (drop > 0) begin
        if0.dma_req = 1'b0; if0.dma_single = 1'b0; drop--;
      end else begin
        if0.dma_req = use_req; if0.dma_single = use_single;
      end
      if (done0) fin = 1;
    end
    if0.dma_req = 1'b0; if0.dma_single = 1'b0;
    chk({tag, "_done_seen"}, fin, 1);
    chk({tag, "_reads"}, rd_cnt, len);
    chk({tag, "_stream_beats"}, st_cnt, len);
    chk({tag, "_stream_order_errs"}, bad, 0);
    chk({tag, "_acks"}, ack_cnt, len / per_ack);
    chk({tag, "_ack_spacing_errs"}, bad_ack, 0);
  endtask

  task automatic wait_ack0(input string tag);
    bit seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(posedge clk); #1;
      start0 = 1'b0;
      if (if0.dma_ack) seen = 1;
    end
    chk({tag, "_ack_seen"}, seen, 1);
  endtask

  task automatic wait_done0(input string tag);
    bit seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(posedge clk); #1;
      if (done0) seen = 1;
    end
    chk({tag, "_done_seen"}, seen, 1);
  endtask

  vec_t vecs[$];

  initial begin
    // single-beat path, zero-length job, enable gating, start while busy
    //                st len en rq sg wt rdy rd        | b d a r v data
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 32'h0,      1, 0, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 32'h0,      0, 1, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 32'h0,      0, 0, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 2, 1, 0, 0, 0, 0, 32'h0,      1, 0, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 0, 1, 1, 0, 32'h0,      1, 0, 0, 1, 0, 32'h0));
    vecs.push_back(mk(1, 5, 1, 0, 1, 1, 0, 32'h0,      1, 0, 0, 1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0, 32'hA1A1,   1, 0, 0, 0, 1, 32'hA1A1));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0, 32'hFFFF,   1, 0, 0, 0, 1, 32'hA1A1));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 1, 32'hFFFF,   1, 0, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0, 32'h0,      1, 0, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 5, 1, 0, 1, 0, 0, 32'h0,      1, 0, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 32'h0,      1, 0, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 32'h0,      1, 0, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 0, 32'h0,      1, 0, 0, 1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 0, 32'hB2B2,   1, 0, 0, 0, 1, 32'hB2B2));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 32'h0,      1, 0, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 32'h0,      1, 0, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 32'h0,      0, 1, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 32'h0,      0, 0, 0, 0, 0, 32'h0));

    reset_n = 1'b0;
    start0 = 0; enable0 = 1; xfer_len0 = 0; start1 = 0; enable1 = 1; xfer_len1 = 0;
    if0.dma_req = 0; if0.dma_single = 0; if0.avm_readdata = 0; if0.avm_waitrequest = 0;
    if0.st_ready_i = 0; if0.st_data_i = 0; if0.st_valid_i = 0;
    if1.dma_req = 0; if1.dma_single = 0; if1.avm_readdata = 0; if1.avm_waitrequest = 0;
    if1.st_ready_i = 0; if1.st_data_i = 0; if1.st_valid_i = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs_dut0", |{busy0, done0, err0, if0.dma_ack, if0.avm_read, if0.avm_write,
        if0.avm_writedata, if0.st_valid_o, if0.st_data_o, if0.st_ready_o}, 0);
    chk("reset_outputs_dut1", |{busy1, done1, err1, if1.dma_ack, if1.avm_read, if1.avm_write,
        if1.avm_writedata, if1.st_valid_o, if1.st_data_o, if1.st_ready_o}, 0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      start0 = vecs[i].st; xfer_len0 = vecs[i].len; enable0 = vecs[i].en;
      if0.dma_req = vecs[i].rq; if0.dma_single = vecs[i].sg;
      if0.avm_waitrequest = vecs[i].wt; if0.st_ready_i = vecs[i].rdy;
      if0.avm_readdata = vecs[i].rd;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_busy_done_ack_read_valid", i),
          {busy0, done0, if0.dma_ack, if0.avm_read, if0.st_valid_o},
          {vecs[i].b, vecs[i].d, vecs[i].a, vecs[i].r, vecs[i].v});
      if (vecs[i].v) chk($sformatf("vec%0d_st_data", i), if0.st_data_o, vecs[i].dat);
    end
    start0 = 0; if0.dma_req = 0; if0.dma_single = 0;

    // two bursts of 8
    run_dir0(16, 1, 0, 8, "burst16");
    // req+single with fewer than BURST_LEN left: singles only
    run_dir0(3, 1, 1, 1, "single3");

    // DIR=1: 3-cycle stall on every write, one burst
    begin
      int wr_cnt = 0, sent = 0, ack_cnt = 0, drop = 0, stall = 0;
      int bad_data = 0, rdy_dbl = 0, wr_cycles = 0, wrong_dir = 0;
      bit fin = 0, prev_rdy = 0;
      start1 = 1'b1; xfer_len1 = 16'd8; enable1 = 1'b1; if1.dma_req = 1'b1;
      if1.st_valid_i = 1'b1; if1.st_data_i = 32'h2000; if1.avm_waitrequest = 1'b0;
      for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
        @(posedge clk); #1;
        start1 = 1'b0;
        if1.st_data_i = 32'h2000 + 32'(sent);
        if (if1.st_ready_o) begin
          if (prev_rdy) rdy_dbl++;
          sent++;
        end
        prev_rdy = if1.st_ready_o;
        if (if1.avm_read || if1.st_valid_o) wrong_dir++;
        if (if1.avm_write) begin
          wr_cycles++;
          if (if1.avm_writedata !== 32'h2000 + 32'(wr_cnt)) bad_data++;
          if (stall < 3) begin
            if1.avm_waitrequest = 1'b1; stall++;
          end else begin
            if1.avm_waitrequest = 1'b0; stall = 0; wr_cnt++;
          end
        end else begin
          if1.avm_waitrequest = 1'b0;
        end
        if (if1.dma_ack) begin ack_cnt++; drop = 2; end
        if (drop > 0) begin if1.dma_req = 1'b0; drop--; end
        else if1.dma_req = 1'b1;
        if (done1) fin = 1;
      end
      if1.dma_req = 1'b0; if1.st_valid_i = 1'b0;
      chk("dir1_done_seen", fin, 1);
      chk("dir1_writes", wr_cnt, 8);
      chk("dir1_write_cycles", wr_cycles, 32);
      chk("dir1_writedata_errs", bad_data, 0);
      chk("dir1_stream_taken", sent, 8);
      chk("dir1_ready_multi_cycle", rdy_dbl, 0);
      chk("dir1_acks", ack_cnt, 1);
      chk("dir1_wrong_dir_outputs", wrong_dir, 0);
    end

    // single held after ack: no new beat until released
    begin
      int hold_reads = 0;
      start0 = 1'b1; xfer_len0 = 16'd2; enable0 = 1'b1; if0.dma_single = 1'b1;
      if0.avm_waitrequest = 1'b0; if0.st_ready_i = 1'b1;
      wait_ack0("hold");
      for (int c = 0; c < 20; c++) begin
        @(posedge clk); #1;
        if (if0.avm_read || if0.dma_ack) hold_reads++;
      end
      chk("hold_no_beat", hold_reads, 0);
      chk("hold_busy", busy0, 1);
`ifdef DMA_RESP_TIMEOUT_EN
      repeat (260) @(posedge clk);
      #1;
      chk("hold_timeout_err", err0, 1);
      chk("hold_timeout_busy", busy0, 0);
      if0.dma_single = 1'b0;
`else
      chk("hold_err_zero", err0, 0);
      if0.dma_single = 1'b0;
      @(posedge clk); #1;
      if0.dma_single = 1'b1;
      wait_ack0("hold_second");
      if0.dma_single = 1'b0;
      wait_done0("hold");
`endif
    end

    // asynchronous reset during beat 4 of a burst
    begin
      int rd_cnt = 0, acks = 0;
      bit found = 0;
      start0 = 1'b1; xfer_len0 = 16'd16; enable0 = 1'b1; if0.dma_req = 1'b1;
      if0.dma_single = 1'b0; if0.avm_waitrequest = 1'b0; if0.st_ready_i = 1'b1;
      for (int c = 0; c < 100 && !found; c++) begin
        @(posedge clk); #1;
        start0 = 1'b0;
        if (if0.dma_ack) acks++;
        if (if0.avm_read) begin
          if (rd_cnt == 3) found = 1;
          else rd_cnt++;
        end
      end
      chk("rst_beat4_reached", found, 1);
      if0.avm_waitrequest = 1'b1;
      #2 reset_n = 1'b0;
      #1;
      chk("rst_mid_outputs_zero", |{busy0, done0, err0, if0.dma_ack, if0.avm_read, if0.avm_write,
          if0.avm_writedata, if0.st_valid_o, if0.st_data_o, if0.st_ready_o}, 0);
      @(negedge clk); reset_n = 1'b1;
      if0.avm_waitrequest = 1'b0;
      for (int c = 0; c < 6; c++) begin
        @(posedge clk); #1;
        if (if0.dma_ack || done0 || busy0 || if0.avm_read) acks++;
      end
      chk("rst_no_ack_after", acks, 0);
      if0.dma_req = 1'b0;
      run_dir0(3, 1, 1, 1, "post_rst");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dma_req_responder.md
DMA_REQ_RESPONDER -- requirements
Module: dma_req_responder

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data width of the peripheral register and the stream.
REQ-002 SHALL have parameter BURST_LEN, default 8, number of beats serviced per burst request (2..255).
REQ-003 SHALL have parameter CNT_W, default 16, width of the transfer-length counter.
REQ-004 SHALL have parameter DIR, default 0 (0: peripheral->stream via reads; 1: stream->peripheral via writes).
REQ-005 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  sole clock; reset_n  in  1  async active-low reset.
REQ-006 SHALL have: start  in  1  one-cycle pulse that loads xfer_len and begins a job.
REQ-007 SHALL have: xfer_len  in  CNT_W  total beats for the job.
REQ-008 SHALL have: enable  in  1  low = accept no new requests; the request in progress still completes.
REQ-009 SHALL have: busy  out  1  job active; done  out  1  one-cycle job-complete pulse; err  out  1  sticky handshake error.
REQ-010 SHALL have: dma_req  in  1  burst request; dma_single  in  1  single request; dma_ack  out  1  request acknowledge (peripheral side of the f2h DMA request handshake).
REQ-011 SHALL have: avm_read  out  1; avm_write  out  1; avm_writedata  out  DATA_W; avm_readdata  in  DATA_W; avm_waitrequest  in  1  (Avalon-MM master to the peripheral data register).
REQ-012 SHALL have: st_data_o  out  DATA_W; st_valid_o  out  1; st_ready_i  in  1  (used when DIR=0).
REQ-013 SHALL have: st_data_i  in  DATA_W; st_valid_i  in  1; st_ready_o  out  1  (used when DIR=1; unused outputs tie to 0).

Function
REQ-014 SHALL implement FSM IDLE->ARM->BEAT->ACK->REL->(ARM|IDLE).
REQ-015 IDLE: start loads remaining=xfer_len, sets busy and enters ARM; if xfer_len=0, done pulses on the next cycle and the FSM returns to IDLE without asserting dma_ack.
REQ-016 ARM with enable=1: if dma_req=1 and remaining>=BURST_LEN, SHALL set beats=BURST_LEN; otherwise, if dma_single=1, SHALL set beats=1; otherwise SHALL stay in ARM. Burst has priority over single.
REQ-017 BEAT, DIR=0: avm_read held until a cycle with avm_waitrequest=0; readdata captured in that cycle; st_valid_o held with stable data until st_ready_i=1; no overlap between beats.
REQ-018 BEAT, DIR=1: wait for st_valid_i; assert st_ready_o for exactly one cycle to latch the data; hold avm_write and avm_writedata until avm_waitrequest=0.
REQ-019 Each completed beat SHALL decrement remaining and beats; when beats reaches 0, go to ACK.
REQ-020 ACK: dma_ack=1 for exactly one cycle, then REL.
REQ-021 REL: wait until dma_req=0 and dma_single=0; then go to IDLE with a done pulse and busy=0 if remaining=0, else go to ARM.
REQ-022 start while busy=1 SHALL be ignored.
REQ-023 Requests present on the ARM entry cycle SHALL be sampled in that same cycle (0-cycle decision latency).

Reset
REQ-024 reset_n low SHALL asynchronously force IDLE, with remaining=0 and all outputs 0 (busy, done, err, dma_ack, avm_read, avm_write, avm_writedata, st_valid_o, st_data_o, st_ready_o).
REQ-025 Reset mid-beat SHALL abandon the beat without producing an ack or a done pulse.

Configuration
REQ-026 With DMA_RESP_TIMEOUT_EN defined, an 8-bit counter SHALL run in REL; if it reaches 255 without both requests released, err SHALL be set (sticky until reset) and the FSM SHALL go to IDLE with busy=0 and no done pulse.
REQ-027 Without DMA_RESP_TIMEOUT_EN, REL SHALL wait indefinitely and err SHALL be constant 0.

Verification
REQ-028 DIR=0, xfer_len=16, dma_req held high, waitrequest=0, st_ready_i=1 -> 8 reads, ack, 8 reads, ack, done; stream order matches readdata.
REQ-029 DIR=0, xfer_len=3, dma_req and dma_single both high -> three single-beat ack cycles, no burst, done after the third release.
REQ-030 DIR=1, xfer_len=8, waitrequest high for 3 cycles on each write -> avm_writedata stable across the stall; exactly 8 writes; one ack.
REQ-031 dma_single held high for 20 cycles after ack -> no new beat until release; with macro: err=1 after 255 cycles.
REQ-032 reset_n pulsed low during beat 4 of a burst -> outputs 0 immediately; no ack; the next start behaves as from a fresh reset.
REQ-033 xfer_len=0 start -> done on the next cycle, dma_ack never asserted; start while busy ignored.
